spi_sensor_poller: RTL and testbench

Parametrised successor of the SPI temperature-sensor polling pair: one FSM that combines the periodic sampling timer, the SPI command/read sequencer and the change-threshold comparator. Every period it shifts a command byte plus NumBytes dummy bytes through the SPI master FIFO and assembles the NumBytes response bytes into one value. It reports the value to the CPU only when it differs from the last reported value by more than a threshold. It sits between the reconfigurable-module SPI master port and the CPU interrupt/parameter interface.

---
 rtl/spi_sensor_poller.sv | 168 ++++++++++++++++
 tb/tb_spi_sensor_poller.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_sensor_poller.sv
// Periodic SPI sensor poller: command + NumBytes dummy bytes per period, report on change > threshold.
// Period preset+1 cycles Idle->Write; TX stalls on FIFOFull, RX stalls on FIFOEmpty, frames never truncated.
module spi_sensor_poller #(
    parameter int DataWidth    = 8,
    parameter int NumBytes     = 2,
    parameter int CounterWidth = 32,
    localparam int ValueWidth  = NumBytes * DataWidth
) (
    input  logic                    Clk_i,
    input  logic                    Reset_n_i,
    input  logic                    Enable_i,
    output logic                    CpuIntr_o,
    output logic [ValueWidth-1:0]   SensorValue_o,
    output logic                    SensorCS_n_o,
    output logic                    SPI_Write_o,
    output logic                    SPI_ReadNext_o,
    output logic [DataWidth-1:0]    SPI_Data_o,
    input  logic [DataWidth-1:0]    SPI_Data_i,
    input  logic                    SPI_FIFOFull_i,
    input  logic                    SPI_FIFOEmpty_i,
    input  logic                    SPI_Transmission_i,
    input  logic [DataWidth-1:0]    ParamCommand_i,
    input  logic [CounterWidth-1:0] ParamCounterPreset_i,
    input  logic [ValueWidth-1:0]   ParamThreshold_i
);

    typedef enum logic [2:0] {
        ST_DISABLED,
        ST_IDLE,
        ST_WRITE,
        ST_WAIT,
        ST_READ,
        ST_COMPARE
    } state_t;

    localparam logic [2:0] LastIdx = 3'(NumBytes);

    state_t                  state, state_next;
    logic [CounterWidth-1:0] counter, counter_next;
    logic                    first, first_next;
    logic [2:0]              idx, idx_next;
    logic [ValueWidth-1:0]   shreg, shreg_next;
    logic [ValueWidth-1:0]   value_next;
    logic [ValueWidth-1:0]   shift_in;
    logic [ValueWidth-1:0]   diff;
    logic                    intr_next;
    logic                    cs_n_next;

    // Response bytes arrive MSB first; a single-byte value is just the RX byte.
    if (NumBytes == 1) begin : g_shift_single
        assign shift_in = SPI_Data_i;
    end else begin : g_shift_multi
        assign shift_in = {shreg[ValueWidth-DataWidth-1:0], SPI_Data_i};
    end

    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            state <= ST_DISABLED;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            counter       <= '0;
            first         <= 1'b1;
            idx           <= '0;
            shreg         <= '0;
            SensorValue_o <= '0;
            CpuIntr_o     <= 1'b0;
            SensorCS_n_o  <= 1'b1;
        end else begin
            counter       <= counter_next;
            first         <= first_next;
            idx           <= idx_next;
            shreg         <= shreg_next;
            SensorValue_o <= value_next;
            CpuIntr_o     <= intr_next;
            SensorCS_n_o  <= cs_n_next;
        end
    end

    always_comb begin
        state_next     = state;
        counter_next   = counter;
        first_next     = first;
        idx_next       = idx;
        shreg_next     = shreg;
        value_next     = SensorValue_o;
        intr_next      = 1'b0;
        cs_n_next      = SensorCS_n_o;
        SPI_Write_o    = 1'b0;
        SPI_ReadNext_o = 1'b0;
        SPI_Data_o     = '0;
        // Larger minus smaller keeps the distance unsigned without an extra carry bit.
        diff = (shreg >= SensorValue_o) ? (shreg - SensorValue_o) : (SensorValue_o - shreg);

        case (state)
            ST_DISABLED: begin
                cs_n_next = 1'b1;
                if (Enable_i) begin
                    state_next   = ST_IDLE;
                    counter_next = ParamCounterPreset_i;
                    first_next   = 1'b1;
                end
            end
            ST_IDLE: begin
                if (!Enable_i) begin
                    state_next = ST_DISABLED;
                end else if (counter == '0) begin
                    state_next = ST_WRITE;
                    idx_next   = '0;
                    cs_n_next  = 1'b0;
                end else begin
                    counter_next = counter - CounterWidth'(1);
                end
            end
            ST_WRITE: begin
                SPI_Data_o = (idx == '0) ? ParamCommand_i : '0;
                if (!SPI_FIFOFull_i) begin
                    SPI_Write_o = 1'b1;
                    if (idx == LastIdx) begin
                        idx_next   = '0;
                        state_next = ST_WAIT;
                    end else begin
                        idx_next = idx + 3'd1;
                    end
                end
            end
            ST_WAIT: begin
                if (!SPI_Transmission_i && !SPI_FIFOEmpty_i) begin
                    state_next = ST_READ;
                end
            end
            ST_READ: begin
                if (!SPI_FIFOEmpty_i) begin
                    SPI_ReadNext_o = 1'b1;
                    // Byte 0 is the echo of the command and carries no data.
                    if (idx != '0) begin
                        shreg_next = shift_in;
                    end
                    if (idx == LastIdx) begin
                        idx_next   = '0;
                        cs_n_next  = 1'b1;
                        state_next = ST_COMPARE;
                    end else begin
                        idx_next = idx + 3'd1;
                    end
                end
            end
            ST_COMPARE: begin
                if (first || (diff > ParamThreshold_i)) begin
                    value_next = shreg;
                    intr_next  = 1'b1;
                end
                first_next   = 1'b0;
                counter_next = ParamCounterPreset_i;
                state_next   = Enable_i ? ST_IDLE : ST_DISABLED;
            end
            default: begin
                state_next = ST_DISABLED;
                cs_n_next  = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_sensor_poller.sv
// Directed bench: SPI FIFO model around a 2-byte poller, plus 1-byte and 4-byte instances for width checks.
module tb_spi_sensor_poller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- main DUT (NumBytes = 2) ----------------
    logic        rst_n;
    logic        en;
    logic        intr, cs_n, wr, rdn;
    logic [15:0] value;
    logic [7:0]  dat_o, dat_i;
    logic        full_f, empty_f, empty, trans;
    logic [7:0]  cmd;
    logic [31:0] preset;
    logic [15:0] thr;

    logic [7:0]  rx_mem [0:15];
    int          rx_rd = 0;
    int          rx_wr = 0;
    assign empty = (rx_rd == rx_wr) || empty_f;
    assign dat_i = rx_mem[rx_rd % 16];

    spi_sensor_poller #(.DataWidth(8), .NumBytes(2), .CounterWidth(32)) dut (
        .Clk_i(clk), .Reset_n_i(rst_n), .Enable_i(en),
        .CpuIntr_o(intr), .SensorValue_o(value), .SensorCS_n_o(cs_n),
        .SPI_Write_o(wr), .SPI_ReadNext_o(rdn), .SPI_Data_o(dat_o),
        .SPI_Data_i(dat_i), .SPI_FIFOFull_i(full_f), .SPI_FIFOEmpty_i(empty),
        .SPI_Transmission_i(trans), .ParamCommand_i(cmd),
        .ParamCounterPreset_i(preset), .ParamThreshold_i(thr)
    );

    // ---------------- width DUTs (NumBytes = 1 and 4), always-ready SPI ----------------
    logic        en1, intr1, cs1_n, wr1, rd1;
    logic [7:0]  v1, do1;
    logic [7:0]  di1 = 8'h20;
    logic        en4, intr4, cs4_n, wr4, rd4;
    logic [31:0] v4;
    logic [7:0]  do4;
    logic [7:0]  di4 = 8'h10;

    spi_sensor_poller #(.DataWidth(8), .NumBytes(1), .CounterWidth(8)) dut1 (
        .Clk_i(clk), .Reset_n_i(rst_n), .Enable_i(en1),
        .CpuIntr_o(intr1), .SensorValue_o(v1), .SensorCS_n_o(cs1_n),
        .SPI_Write_o(wr1), .SPI_ReadNext_o(rd1), .SPI_Data_o(do1),
        .SPI_Data_i(di1), .SPI_FIFOFull_i(1'b0), .SPI_FIFOEmpty_i(1'b0),
        .SPI_Transmission_i(1'b0), .ParamCommand_i(8'hA5),
        .ParamCounterPreset_i(8'd0), .ParamThreshold_i(8'd0)
    );

    spi_sensor_poller #(.DataWidth(8), .NumBytes(4), .CounterWidth(16)) dut4 (
        .Clk_i(clk), .Reset_n_i(rst_n), .Enable_i(en4),
        .CpuIntr_o(intr4), .SensorValue_o(v4), .SensorCS_n_o(cs4_n),
        .SPI_Write_o(wr4), .SPI_ReadNext_o(rd4), .SPI_Data_o(do4),
        .SPI_Data_i(di4), .SPI_FIFOFull_i(1'b0), .SPI_FIFOEmpty_i(1'b0),
        .SPI_Transmission_i(1'b0), .ParamCommand_i(8'hA5),
        .ParamCounterPreset_i(16'd0), .ParamThreshold_i(32'd0)
    );

    // ---------------- monitors / FIFO models ----------------
    logic       wr_seen, rd_seen, rd1_seen, rd4_seen;
    logic [7:0] dat_seen;
    logic [7:0] tx_log [0:63];
    int tx_cnt = 0, intr_cnt = 0, cs_low_cnt = 0, proto_err = 0;
    int i1 = 0, w1 = 0, run1 = 0, last_run1 = 0, hrun1 = 0, gap1 = 0;
    int i4 = 0, w4 = 0, run4 = 0, last_run4 = 0, hrun4 = 0, gap4 = 0;
    logic [7:0]  v1s [0:3];
    logic [31:0] v4s [0:3];

    always @(negedge clk) begin
        wr_seen  = wr;
        rd_seen  = rdn;
        dat_seen = dat_o;
        rd1_seen = rd1;
        rd4_seen = rd4;
        if (intr) intr_cnt++;
        if (!cs_n) cs_low_cnt++;
        if ((wr && rdn) || ((wr || rdn) && cs_n)) proto_err++;
        if ((wr1 && rd1) || ((wr1 || rd1) && cs1_n)) proto_err++;
        if ((wr4 && rd4) || ((wr4 || rd4) && cs4_n)) proto_err++;
        if (wr1) w1++;
        if (wr4) w4++;
        if (intr1) begin if (i1 < 4) v1s[i1] = v1; i1++; end
        if (intr4) begin if (i4 < 4) v4s[i4] = v4; i4++; end
        if (!cs1_n) begin if (hrun1 > 0) gap1 = hrun1; hrun1 = 0; run1++; end
        else begin if (run1 > 0) last_run1 = run1; run1 = 0; hrun1++; end
        if (!cs4_n) begin if (hrun4 > 0) gap4 = hrun4; hrun4 = 0; run4++; end
        else begin if (run4 > 0) last_run4 = run4; run4 = 0; hrun4++; end
    end

    always @(posedge clk) begin
        #1;
        if (wr_seen) begin tx_log[tx_cnt % 64] = dat_seen; tx_cnt++; end
        if (rd_seen) rx_rd++;
        if (rd1_seen) di1 = di1 + 8'd1;
        if (rd4_seen) di4 = di4 + 8'd1;
    end

    // ---------------- helpers (no comparisons) ----------------
    task automatic push_rx(input logic [7:0] b);
        rx_mem[rx_wr % 16] = b;
        rx_wr++;
    endtask

    task automatic wait_cs(input logic lvl, input int limit, output int n);
        n = 0;
        while (1) begin
            @(posedge clk); #1;
            n++;
            if (cs_n === lvl) return;
            if (n >= limit) begin n = -1; return; end
        end
    endtask

    task automatic wait_rdn(input int limit, output int n);
        n = 0;
        while (1) begin
            @(posedge clk); #1;
            n++;
            if (rdn === 1'b1) return;
            if (n >= limit) begin n = -1; return; end
        end
    endtask

    task automatic run_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             output int ok);
        int n;
        ok = 1;
        push_rx(b0); push_rx(b1); push_rx(b2);
        wait_cs(1'b0, 100, n);
        if (n < 0) ok = 0;
        wait_cs(1'b1, 100, n);
        if (n < 0) ok = 0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n: got %b expected 1", cs_n); end
        checks++; if (intr !== 1'b0 || value !== 16'h0) begin errors++; $display("FAIL reset_intr_value: got intr=%b value=%h expected 0/0000", intr, value); end
        checks++; if (wr !== 1'b0 || rdn !== 1'b0 || dat_o !== 8'h00) begin errors++; $display("FAIL reset_spi: got wr=%b rd=%b dat=%h expected 0/0/00", wr, rdn, dat_o); end
        rst_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        checks++; if (cs_low_cnt !== 0 || tx_cnt !== 0) begin errors++; $display("FAIL disabled_idle: got cs_low=%0d tx=%0d expected 0/0", cs_low_cnt, tx_cnt); end
    endtask

    task automatic test_basic;
        int n, tx0, i0;
        tx0 = tx_cnt; i0 = intr_cnt;
        push_rx(8'hFF); push_rx(8'h0C); push_rx(8'h80);
        en = 1'b1;
        wait_cs(1'b0, 50, n);
        checks++; if (n !== 11) begin errors++; $display("FAIL basic_cs_delay: got %0d expected 11", n); end
        wait_cs(1'b1, 50, n);
        checks++; if (n < 0) begin errors++; $display("FAIL basic_frame_end: got timeout expected cs_n high"); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (tx_cnt - tx0 !== 3) begin errors++; $display("FAIL basic_tx_count: got %0d expected 3", tx_cnt - tx0); end
        checks++; if (tx_log[tx0 % 64] !== 8'h50 || tx_log[(tx0 + 1) % 64] !== 8'h00 || tx_log[(tx0 + 2) % 64] !== 8'h00)
            begin errors++; $display("FAIL basic_tx_bytes: got %h %h %h expected 50 00 00", tx_log[tx0 % 64], tx_log[(tx0 + 1) % 64], tx_log[(tx0 + 2) % 64]); end
        checks++; if (rx_rd !== rx_wr) begin errors++; $display("FAIL basic_pops: got %0d left expected 0", rx_wr - rx_rd); end
        checks++; if (value !== 16'h0C80) begin errors++; $display("FAIL basic_value: got %h expected 0c80", value); end
        checks++; if (intr_cnt - i0 !== 1) begin errors++; $display("FAIL basic_intr: got %0d pulse cycles expected 1", intr_cnt - i0); end
    endtask

    task automatic test_threshold;
        int ok, i0;
        i0 = intr_cnt;
        run_frame(8'hAA, 8'h0C, 8'h90, ok);
        checks++; if (ok !== 1 || intr_cnt - i0 !== 0 || value !== 16'h0C80)
            begin errors++; $display("FAIL thr_within: got ok=%0d intr=%0d value=%h expected 1/0/0c80", ok, intr_cnt - i0, value); end
        i0 = intr_cnt;
        run_frame(8'hAA, 8'h0C, 8'h91, ok);
        checks++; if (ok !== 1 || intr_cnt - i0 !== 1 || value !== 16'h0C91)
            begin errors++; $display("FAIL thr_above: got ok=%0d intr=%0d value=%h expected 1/1/0c91", ok, intr_cnt - i0, value); end
        i0 = intr_cnt;
        run_frame(8'hAA, 8'h0C, 8'h80, ok);
        checks++; if (ok !== 1 || intr_cnt - i0 !== 1 || value !== 16'h0C80)
            begin errors++; $display("FAIL thr_down: got ok=%0d intr=%0d value=%h expected 1/1/0c80", ok, intr_cnt - i0, value); end
    endtask

    task automatic test_backpressure;
        int n, tx0, r0, i0;
        tx0 = tx_cnt; i0 = intr_cnt;
        push_rx(8'h50); push_rx(8'h12); push_rx(8'h34);
        r0 = rx_rd;
        wait_cs(1'b0, 50, n);
        full_f = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checks++; if (n < 0 || tx_cnt - tx0 !== 0) begin errors++; $display("FAIL bp_full_hold: got n=%0d writes=%0d expected 0 writes", n, tx_cnt - tx0); end
        full_f = 1'b0;
        wait_rdn(50, n);
        empty_f = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (n < 0 || rx_rd - r0 !== 0) begin errors++; $display("FAIL bp_empty_hold: got n=%0d pops=%0d expected 0 pops", n, rx_rd - r0); end
        empty_f = 1'b0;
        wait_cs(1'b1, 50, n);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (tx_cnt - tx0 !== 3 || rx_rd - r0 !== 3) begin errors++; $display("FAIL bp_counts: got writes=%0d pops=%0d expected 3/3", tx_cnt - tx0, rx_rd - r0); end
        checks++; if (tx_log[tx0 % 64] !== 8'h50 || tx_log[(tx0 + 1) % 64] !== 8'h00 || tx_log[(tx0 + 2) % 64] !== 8'h00)
            begin errors++; $display("FAIL bp_tx_bytes: got %h %h %h expected 50 00 00", tx_log[tx0 % 64], tx_log[(tx0 + 1) % 64], tx_log[(tx0 + 2) % 64]); end
        checks++; if (value !== 16'h1234 || intr_cnt - i0 !== 1) begin errors++; $display("FAIL bp_result: got value=%h intr=%0d expected 1234/1", value, intr_cnt - i0); end
    endtask

    task automatic test_disable_mid;
        int n, i0, c0, t0, ok;
        i0 = intr_cnt;
        push_rx(8'h50); push_rx(8'h56); push_rx(8'h78);
        wait_rdn(100, n);
        en = 1'b0;
        wait_cs(1'b1, 50, n);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (n < 0 || rx_rd !== rx_wr) begin errors++; $display("FAIL dis_frame_complete: got n=%0d left=%0d expected frame done", n, rx_wr - rx_rd); end
        checks++; if (value !== 16'h5678 || intr_cnt - i0 !== 1) begin errors++; $display("FAIL dis_report: got value=%h intr=%0d expected 5678/1", value, intr_cnt - i0); end
        c0 = cs_low_cnt; t0 = tx_cnt;
        repeat (30) @(posedge clk);
        #1;
        checks++; if (cs_low_cnt !== c0 || tx_cnt !== t0) begin errors++; $display("FAIL dis_quiet: got cs_low=%0d tx=%0d expected 0/0", cs_low_cnt - c0, tx_cnt - t0); end
        i0 = intr_cnt;
        en = 1'b1;
        run_frame(8'h50, 8'h56, 8'h79, ok);
        checks++; if (ok !== 1 || value !== 16'h5679 || intr_cnt - i0 !== 1) begin errors++; $display("FAIL reenable_first: got ok=%0d value=%h intr=%0d expected 1/5679/1", ok, value, intr_cnt - i0); end
    endtask

    task automatic test_reset_mid;
        int n, c0, t0;
        full_f = 1'b1;
        wait_cs(1'b0, 50, n);
        rst_n = 1'b0;
        #1;
        checks++; if (n < 0 || cs_n !== 1'b1) begin errors++; $display("FAIL rst_cs_async: got n=%0d cs_n=%b expected 1", n, cs_n); end
        checks++; if (wr !== 1'b0 || rdn !== 1'b0 || dat_o !== 8'h00 || intr !== 1'b0 || value !== 16'h0)
            begin errors++; $display("FAIL rst_outputs: got wr=%b rd=%b dat=%h intr=%b value=%h expected all 0", wr, rdn, dat_o, intr, value); end
        en = 1'b0; full_f = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        c0 = cs_low_cnt; t0 = tx_cnt;
        repeat (20) @(posedge clk);
        #1;
        checks++; if (cs_low_cnt !== c0 || tx_cnt !== t0 || cs_n !== 1'b1) begin errors++; $display("FAIL rst_quiet: got cs_low=%0d tx=%0d expected 0/0", cs_low_cnt - c0, tx_cnt - t0); end
    endtask

    task automatic test_width;
        int n;
        en1 = 1'b1; en4 = 1'b1;
        n = 0;
        while ((i1 < 2 || i4 < 2) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        en1 = 1'b0; en4 = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        checks++; if (i1 < 2 || i4 < 2) begin errors++; $display("FAIL width_timeout: got i1=%0d i4=%0d expected >=2", i1, i4); end
        checks++; if (v4s[0] !== 32'h11121314 || v4s[1] !== 32'h16171819) begin errors++; $display("FAIL width4_value: got %h %h expected 11121314 16171819", v4s[0], v4s[1]); end
        checks++; if (v1s[0] !== 8'h21 || v1s[1] !== 8'h23) begin errors++; $display("FAIL width1_value: got %h %h expected 21 23", v1s[0], v1s[1]); end
        checks++; if (last_run4 !== 11 || last_run1 !== 5) begin errors++; $display("FAIL width_cs_len: got %0d/%0d expected 11/5", last_run4, last_run1); end
        checks++; if (gap4 !== 2 || gap1 !== 2) begin errors++; $display("FAIL width_gap: got %0d/%0d expected 2/2", gap4, gap1); end
        checks++; if (w4 !== 5 * i4 || w1 !== 2 * i1) begin errors++; $display("FAIL width_writes: got w4=%0d w1=%0d expected %0d/%0d", w4, w1, 5 * i4, 2 * i1); end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; en1 = 1'b0; en4 = 1'b0;
        full_f = 1'b0; empty_f = 1'b0; trans = 1'b0;
        cmd = 8'h50; preset = 32'd9; thr = 16'h0010;
        for (int i = 0; i < 16; i++) rx_mem[i] = 8'h00;
        test_reset;
        test_basic;
        test_threshold;
        test_backpressure;
        test_disable_mid;
        test_reset_mid;
        test_width;
        checks++; if (proto_err !== 0) begin errors++; $display("FAIL protocol: got %0d violations expected 0", proto_err); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
